// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Iteration counter width; at least one bit so N=1 still elaborates.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder_subtractor.sv
// 2N-bit ripple-carry adder/subtractor: s = a + b (op=0) or a - b (op=1).
module ripple_carry_adder_subtractor #(
    parameter int N = 16
) (
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    input  logic           op,
    output logic [2*N-1:0] s,
    output logic           c,
    output logic           v
);
    localparam int W = 2 * N;

    logic [W-1:0] b_x;
    logic [W:0]   carry;

    // Subtraction is a + ~b + 1: invert b and inject op as the carry-in.
    assign b_x      = b ^ {W{op}};
    assign carry[0] = op;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_fa
            assign s[gi]         = a[gi] ^ b_x[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
        end
    endgenerate

    assign c = carry[W];
    assign v = carry[W] ^ carry[W-1];

endmodule

// File: rtl/booth_r2_seq_multiplier.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock over a
// shared 2N-bit adder/subtractor; product is presented with a one-cycle done.
module booth_r2_seq_multiplier
    import booth_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);
    localparam int W  = 2 * N;
    localparam int CW = cnt_width(N);

    state_t         state_reg, state_next;
    logic [W-1:0]   acc_reg;
    logic [W-1:0]   msh_reg;
    logic [N-1:0]   q_reg;
    logic           q_m1_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   product_reg;

    logic [1:0]     booth_pair;
    logic           adder_op;
    logic [W-1:0]   adder_sum;
    logic [W-1:0]   acc_next;
    logic           last_step;
    logic           adder_c_unused;
    logic           adder_v_unused;

    ripple_carry_adder_subtractor #(.N(N)) u_addsub (
        .a  (acc_reg),
        .b  (msh_reg),
        .op (adder_op),
        .s  (adder_sum),
        .c  (adder_c_unused),
        .v  (adder_v_unused)
    );

    // Booth decode: 10 -> subtract, 01 -> add, 00/11 -> hold.
    always_comb begin
        booth_pair = {q_reg[0], q_m1_reg};
        adder_op   = (booth_pair == 2'b10) ? OP_SUB : OP_ADD;
        acc_next   = (booth_pair[1] ^ booth_pair[0]) ? adder_sum : acc_reg;
    end

    assign last_step = (state_reg == RUN) && (cnt_reg == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            msh_reg     <= '0;
            q_reg       <= '0;
            q_m1_reg    <= 1'b0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            acc_reg  <= '0;
            msh_reg  <= {{N{multiplicand[N-1]}}, multiplicand};
            q_reg    <= multiplier;
            q_m1_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (state_reg == RUN) begin
            acc_reg  <= acc_next;
            msh_reg  <= msh_reg << 1;
            q_m1_reg <= q_reg[0];
            q_reg    <= q_reg >> 1;
            cnt_reg  <= cnt_reg + 1'b1;
            // Only the finished accumulator is ever exposed on product.
            if (last_step) product_reg <= acc_next;
        end
    end

    assign product = product_reg;

endmodule
